oled_page_flush_ctrl: RTL and testbench

//  Sequences framebuffer-to-OLED flushes for the maze display. On a flush request it walks the

---
 rtl/oled_pkg.sv | 33 +++
 rtl/oled_tx_holdreg.sv | 40 ++++
 rtl/oled_page_flush_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_oled_page_flush_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared constants, state encoding and helpers for the OLED page flusher
package oled_pkg;

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SEL    = 4'd1,
        ST_CMD_PG = 4'd2,
        ST_CMD_CL = 4'd3,
        ST_CMD_CH = 4'd4,
        ST_RD     = 4'd5,
        ST_CAP    = 4'd6,
        ST_DAT    = 4'd7,
        ST_FIN    = 4'd8,
        ST_ERR    = 4'd9
    } oled_state_e;

    // Ceiling log2 for sizing counters and addresses; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oled_tx_holdreg.sv
// rtl/oled_tx_holdreg.sv - valid/ready output register with hold-on-stall and flush-on-error
module oled_tx_holdreg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       is_data_i,
    input  logic       flush_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_byte_o,
    output logic       tx_is_data_o
);

    logic       valid_q;
    logic [7:0] byte_q;
    logic       is_data_q;

    // Payload is only loaded while empty, so it stays put for the whole stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            byte_q    <= 8'h00;
            is_data_q <= 1'b0;
        end else if (flush_i) begin
            valid_q   <= 1'b0;
        end else if (load_i && !valid_q) begin
            valid_q   <= 1'b1;
            byte_q    <= byte_i;
            is_data_q <= is_data_i;
        end else if (valid_q && tx_ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign tx_valid_o   = valid_q;
    assign tx_byte_o    = byte_q;
    assign tx_is_data_o = is_data_q;

endmodule

// File: rtl/oled_page_flush_ctrl.sv
// rtl/oled_page_flush_ctrl.sv - walks dirty framebuffer pages and streams them to the OLED transport
module oled_page_flush_ctrl
    import oled_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int PAGES      = 8,
    parameter int COL_OFFSET = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                init_done_i,
    input  logic                                flush_req_i,
    input  logic [PAGES-1:0]                    dirty_mask_i,
    output logic                                fb_rd_en_o,
    output logic [clog2(PAGES*WIDTH)-1:0]       fb_addr_o,
    input  logic [7:0]                          fb_rdata_i,
    output logic                                tx_valid_o,
    output logic                                tx_is_data_o,
    output logic [7:0]                          tx_byte_o,
    input  logic                                tx_ready_i,
    input  logic                                tx_err_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int AW = clog2(PAGES * WIDTH);
    localparam int PW = (PAGES > 1) ? clog2(PAGES) : 1;
    localparam int CW = (WIDTH > 1) ? clog2(WIDTH) : 1;
    localparam logic [7:0] COL_OFF8 = COL_OFFSET[7:0];

    oled_state_e      state_q, state_d;
    logic [PAGES-1:0] pend_q, pend_d, pend_clr, pend_set, page_bit;
    logic [PW-1:0]    page_q, page_d;
    logic [CW-1:0]    col_q, col_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d;
    logic             ld, ld_is_data, hold_flush, rd_en, accept, in_flight;
    logic [7:0]       ld_byte;

    // Index of the lowest set bit; callers only use it when the mask is non-zero.
    function automatic logic [PW-1:0] lowest_set(input logic [PAGES-1:0] m);
        logic [PW-1:0] r;
        r = '0;
        for (int i = PAGES - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = PW'(i);
            end
        end
        return r;
    endfunction

    assign accept     = tx_valid_o && tx_ready_i;
    assign page_bit   = PAGES'(1) << page_q;
    assign in_flight  = state_q inside {ST_CMD_PG, ST_CMD_CL, ST_CMD_CH, ST_RD, ST_CAP, ST_DAT};
    assign fb_rd_en_o = rd_en;
    assign fb_addr_o  = AW'(page_q) * AW'(WIDTH) + AW'(col_q);
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

    // State, counters, pending-page mask and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            page_q  <= '0;
            col_q   <= '0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            page_q  <= page_d;
            col_q   <= col_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic; an aborted page is re-marked so it is resent from column 0.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        col_d      = col_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        req_d      = req_q | flush_req_i;
        pend_clr   = '0;
        pend_set   = '0;
        ld         = 1'b0;
        ld_byte    = 8'h00;
        ld_is_data = 1'b0;
        hold_flush = 1'b0;
        rd_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A zero-mask request still has to yield a done pulse, hence req_q.
                if (init_done_i && (pend_q != '0 || req_q)) begin
                    state_d = ST_SEL;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_SEL: begin
                if (!init_done_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    req_d = flush_req_i;
                    if (pend_q != '0) begin
                        page_d   = lowest_set(pend_q);
                        pend_clr = PAGES'(1) << lowest_set(pend_q);
                        col_d    = '0;
                        state_d  = ST_CMD_PG;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_CMD_PG, ST_CMD_CL, ST_CMD_CH, ST_DAT: begin
                if (!init_done_i && (!tx_valid_o || accept)) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    pend_set = page_bit;
                end else if (!tx_valid_o) begin
                    ld = 1'b1;
                    case (state_q)
                        ST_CMD_PG: ld_byte = CMD_SET_PAGE | 8'(page_q);
                        ST_CMD_CL: ld_byte = CMD_COL_LO | {4'h0, COL_OFF8[3:0]};
                        ST_CMD_CH: ld_byte = CMD_COL_HI | {4'h0, COL_OFF8[7:4]};
                        default: begin
                            ld_byte    = data_q;
                            ld_is_data = 1'b1;
                        end
                    endcase
                end else if (accept) begin
                    case (state_q)
                        ST_CMD_PG: state_d = ST_CMD_CL;
                        ST_CMD_CL: state_d = ST_CMD_CH;
                        ST_CMD_CH: state_d = ST_RD;
                        default: begin
                            if (col_q == CW'(WIDTH - 1)) begin
                                state_d = ST_SEL;
                            end else begin
                                col_d   = col_q + 1'b1;
                                state_d = ST_RD;
                            end
                        end
                    endcase
                end
            end
            ST_RD: begin
                if (!init_done_i) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    pend_set = page_bit;
                end else begin
                    rd_en   = 1'b1;
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                if (!init_done_i) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    pend_set = page_bit;
                end else begin
                    data_d  = fb_rdata_i;
                    state_d = ST_DAT;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_err_i && state_q != ST_IDLE && state_q != ST_ERR) begin
            state_d    = ST_ERR;
            hold_flush = 1'b1;
            ld         = 1'b0;
            rd_en      = 1'b0;
            done_d     = 1'b0;
            busy_d     = busy_q;
            pend_clr   = '0;
            pend_set   = in_flight ? page_bit : '0;
        end

        pend_d = (pend_q & ~pend_clr) | pend_set | (flush_req_i ? dirty_mask_i : '0);
    end

    oled_tx_holdreg u_holdreg (
        .clk          (clk),
        .reset        (reset),
        .load_i       (ld),
        .byte_i       (ld_byte),
        .is_data_i    (ld_is_data),
        .flush_i      (hold_flush),
        .tx_ready_i   (tx_ready_i),
        .tx_valid_o   (tx_valid_o),
        .tx_byte_o    (tx_byte_o),
        .tx_is_data_o (tx_is_data_o)
    );

endmodule

// File: tb/tb_oled_page_flush_ctrl.sv
// tb/tb_oled_page_flush_ctrl.sv - self-checking bench for oled_page_flush_ctrl
module tb_oled_page_flush_ctrl;

    localparam int W = 128;
    localparam int P = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done_i;
    logic        flush_req_i;
    logic [7:0]  dirty_mask_i;
    logic        fb_rd_en_o;
    logic [9:0]  fb_addr_o;
    logic [7:0]  fb_rdata_i;
    logic        tx_valid_o;
    logic        tx_is_data_o;
    logic [7:0]  tx_byte_o;
    logic        tx_ready_i;
    logic        tx_err_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    oled_page_flush_ctrl #(.WIDTH(W), .PAGES(P), .COL_OFFSET(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .init_done_i  (init_done_i),
        .flush_req_i  (flush_req_i),
        .dirty_mask_i (dirty_mask_i),
        .fb_rd_en_o   (fb_rd_en_o),
        .fb_addr_o    (fb_addr_o),
        .fb_rdata_i   (fb_rdata_i),
        .tx_valid_o   (tx_valid_o),
        .tx_is_data_o (tx_is_data_o),
        .tx_byte_o    (tx_byte_o),
        .tx_ready_i   (tx_ready_i),
        .tx_err_i     (tx_err_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    logic [8:0] tx_q[$];
    int         addr_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         acc_cnt, data_cnt, done_cnt, err_cnt, last_addr;
    logic [7:0] first_byte;
    logic       rand_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_tx;
    logic [8:0] mon_e;
    int         mon_a;

    function automatic logic [7:0] fb_pat(input int a);
        return 8'(a * 37 + (a >> 7) * 11 + 5);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cmds(input int p);
        tx_q.push_back({1'b0, 8'hB0 | 8'(p)});
        tx_q.push_back({1'b0, 8'h00});
        tx_q.push_back({1'b0, 8'h10});
    endtask

    task automatic expect_page(input int p);
        push_cmds(p);
        for (int c = 0; c < W; c++) begin
            tx_q.push_back({1'b1, fb_pat(p * W + c)});
            addr_q.push_back(p * W + c);
        end
    endtask

    // Framebuffer RAM: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        fb_rdata_i <= fb_rd_en_o ? fb_pat(int'(fb_addr_o)) : 8'($urandom);
    end

    // Transport readiness changes just after each active edge.
    always @(posedge clk) begin
        #1;
        tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", int'(tx_valid_o), 1);
                check("stall_byte_held", int'({tx_is_data_o, tx_byte_o}), int'(prev_tx));
            end
            prev_stall = tx_valid_o && !tx_ready_i && !tx_err_i;
            prev_tx    = {tx_is_data_o, tx_byte_o};
            if (tx_valid_o && tx_ready_i && !tx_err_i) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx: got 0x%0h expected none", tx_byte_o);
                end else begin
                    mon_e = tx_q.pop_front();
                    check("tx_is_data", int'(tx_is_data_o), int'(mon_e[8]));
                    check("tx_byte", int'(tx_byte_o), int'(mon_e[7:0]));
                end
                if (acc_cnt == 0) first_byte = tx_byte_o;
                acc_cnt++;
                if (tx_is_data_o) data_cnt++;
            end
            if (fb_rd_en_o) begin
                check("fb_addr_range", int'(fb_addr_o < 10'd1023 || fb_addr_o == 10'd1023), 1);
                if (addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_read: got %0d expected none", fb_addr_o);
                end else begin
                    mon_a = addr_q.pop_front();
                    check("fb_addr", int'(fb_addr_o), mon_a);
                end
                last_addr = int'(fb_addr_o);
            end
            if (done_o) begin
                done_cnt++;
                check("done_busy_low", int'(busy_o), 0);
            end
            if (err_o) begin
                err_cnt++;
                check("err_busy_low", int'(busy_o), 0);
            end
        end
    end

    task automatic start_test();
        @(posedge clk);
        #1;
        acc_cnt  = 0;
        data_cnt = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic pulse_req(input logic [7:0] m);
        @(negedge clk);
        flush_req_i  = 1'b1;
        dirty_mask_i = m;
        @(negedge clk);
        flush_req_i  = 1'b0;
        dirty_mask_i = 8'h00;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) break;
        end
        if (i == budget) check("timeout_done", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_data(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (data_cnt >= n) break;
        end
        if (i == budget) check("timeout_data", data_cnt, n);
    endtask

    task automatic end_checks(input string tag, input int exp_done);
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_done_count"}, done_cnt, exp_done);
        check({tag, "_tx_left"}, tx_q.size(), 0);
        check({tag, "_rd_left"}, addr_q.size(), 0);
        check({tag, "_busy_idle"}, int'(busy_o), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_valid"}, int'(tx_valid_o), 0);
        check({tag, "_tx_byte"}, int'({tx_is_data_o, tx_byte_o}), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_err"}, int'(err_o), 0);
        check({tag, "_rd"}, int'({fb_rd_en_o, fb_addr_o}), 0);
    endtask

    initial begin
        int lat;
        int i;
        reset        = 1'b1;
        init_done_i  = 1'b1;
        flush_req_i  = 1'b0;
        dirty_mask_i = 8'h00;
        tx_err_i     = 1'b0;
        tx_ready_i   = 1'b1;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single page, ready tied high, with first-byte latency.
        start_test();
        expect_page(0);
        @(negedge clk);
        flush_req_i  = 1'b1;
        dirty_mask_i = 8'h01;
        @(posedge clk);
        #1;
        flush_req_i  = 1'b0;
        dirty_mask_i = 8'h00;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (tx_valid_o) begin
                lat = n;
                break;
            end
        end
        check("first_valid_latency", lat, 3);
        wait_done(3000);
        end_checks("t1", 1);
        check("t1_cmd_bytes", acc_cnt - data_cnt, 3);
        check("t1_data_bytes", data_cnt, 128);
        check("t1_last_addr", last_addr, 127);

        // Pages 0 and 7 under random back-pressure.
        start_test();
        rand_ready = 1'b1;
        expect_page(0);
        expect_page(7);
        pulse_req(8'h81);
        wait_done(20000);
        end_checks("t2", 1);
        check("t2_last_addr", last_addr, 1023);
        rand_ready = 1'b0;

        // Page 2 requested while page 0 streams: merged into the same busy period.
        start_test();
        expect_page(0);
        expect_page(2);
        pulse_req(8'h01);
        wait_data(20, 3000);
        pulse_req(8'h04);
        wait_done(5000);
        end_checks("t3", 1);
        check("t3_data_bytes", data_cnt, 256);

        // Transport error on data byte 10 of page 3, then automatic retry.
        start_test();
        push_cmds(3);
        for (int c = 0; c < 10; c++) tx_q.push_back({1'b1, fb_pat(3 * W + c)});
        for (int c = 0; c < 11; c++) addr_q.push_back(3 * W + c);
        expect_page(3);
        pulse_req(8'h08);
        for (i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (tx_valid_o && tx_is_data_o && data_cnt == 10) begin
                tx_err_i = 1'b1;
                @(posedge clk);
                #1;
                tx_err_i = 1'b0;
                break;
            end
        end
        if (i == 2000) check("timeout_err_inject", 0, 1);
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err_o) break;
        end
        check("t4_err_set", int'(err_o), 1);
        check("t4_err_busy", int'(busy_o), 0);
        check("t4_no_done_before_retry", done_cnt, 0);
        @(negedge clk);
        check("t4_err_cleared_on_retry", int'(err_o), 0);
        check("t4_retry_busy", int'(busy_o), 1);
        wait_done(3000);
        end_checks("t4", 1);
        check("t4_err_pulses", err_cnt, 1);

        // Empty mask: done with no traffic.
        start_test();
        pulse_req(8'h00);
        wait_done(50);
        end_checks("t5", 1);
        check("t5_no_tx", acc_cnt, 0);

        // Request held while init is low.
        start_test();
        init_done_i = 1'b0;
        pulse_req(8'h02);
        repeat (20) @(negedge clk);
        check("t6_held_busy", int'(busy_o), 0);
        check("t6_held_no_tx", acc_cnt, 0);
        expect_page(1);
        init_done_i = 1'b1;
        wait_done(3000);
        end_checks("t6", 1);

        // Asynchronous reset during page 5, then a fresh request.
        start_test();
        expect_page(5);
        pulse_req(8'h20);
        wait_data(5, 1000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        tx_q.delete();
        addr_q.delete();
        check("t7_no_done", done_cnt, 0);
        check("t7_no_err", err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t7_pend_lost", int'(busy_o), 0);
        start_test();
        expect_page(5);
        pulse_req(8'h20);
        wait_done(3000);
        end_checks("t7", 1);
        check("t7_first_byte", int'(first_byte), 8'hB5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
